cpu19_core: RTL and testbench

Single-cycle 19-bit CPU with 16x19 register file, 2048x19 instruction ROM, 256x19 data RAM and a 16-entry hardware return stack. Includes an XOR/rotate crypto unit and a 2-point FFT butterfly unit. Every internal decode and datapath signal is exported as a debug output for waveform-level verification.

---
 rtl/cpu19_core.sv | 203 ++++++++++++++++++++
 tb/tb_cpu19_core.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/cpu19_core.sv
// Single-cycle 19-bit CPU: 16x19 register file, 2048-word ROM, 256-word RAM,
// 16-deep return stack, XOR/rotate crypto and 2-point butterfly units.
module cpu19_core #(
  parameter string       IMEM_FILE = "program.mem",
  parameter logic [18:0] ENC_KEY   = 19'h5A5A5
) (
  input  logic        clk,
  input  logic        reset,
  output logic [18:0] instruction_out,
  output logic [3:0]  opcode_out,
  output logic [3:0]  rd_out,
  output logic [3:0]  rs1_out,
  output logic [3:0]  rs2_out,
  output logic [2:0]  alu_op_out,
  output logic [1:0]  funct2_out,
  output logic [2:0]  alu_type_out,
  output logic [2:0]  type_out,
  output logic [10:0] jump_addr_out,
  output logic [10:0] call_addr_out,
  output logic [7:0]  branch_addr_out,
  output logic [7:0]  mem_addr_out,
  output logic [18:0] readdata1_out,
  output logic [18:0] readdata2_out,
  output logic [18:0] alu_b_out,
  output logic [18:0] result_out,
  output logic [18:0] mem_data_out,
  output logic [18:0] write_data_out,
  output logic [18:0] encr_result_out,
  output logic [18:0] fft_result_out,
  output logic        regwrite_out,
  output logic        alu_use_out,
  output logic        branch_en_out,
  output logic        jump_en_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic        call_en_out,
  output logic        ret_en_out,
  output logic        encr_en_out,
  output logic        decr_en_out,
  output logic        fft_en_out,
  output logic [1:0]  pc_src_out,
  output logic        zero_out,
  output logic [18:0] pc_out,
  output logic [18:0] pc_next_out,
  output logic [4:0]  sp_out,
  output logic [18:0] stack_top_out,
  output logic        stack_empty_out,
  output logic        stack_full_out
);
  localparam logic [3:0] OP_ARITH = 4'h1, OP_LOGIC = 4'h2, OP_LOAD = 4'h3, OP_STORE = 4'h4,
                         OP_JMP = 4'h5, OP_BEQ = 4'h6, OP_BNE = 4'h7, OP_CALL = 4'h8,
                         OP_RET = 4'h9, OP_ENC = 4'hA, OP_DEC = 4'hB, OP_FFT = 4'hC,
                         OP_LI = 4'hD, OP_HALT = 4'hE;

  logic [18:0] imem [0:2047];
  logic [18:0] dmem [0:255];
  logic [18:0] regs [0:15];
  logic [18:0] stack [0:15];
  logic [18:0] pc_r;
  logic [4:0]  sp_r;
  logic        zero_r;
  logic [18:0] pc_inc_s, a_s, b_s, enc_s, dec_x_s;
  logic [4:0]  shamt_s;

  // ROM image: zero-filled at elaboration.
  initial begin
    for (int i = 0; i < 2048; i++) imem[i] = 19'd0;
  end

  assign pc_inc_s = pc_r + 19'd1;
  assign a_s      = readdata1_out;
  assign b_s      = readdata2_out;
  assign shamt_s  = b_s[4:0];
  assign enc_s    = {a_s[15:0], a_s[18:16]} ^ ENC_KEY;
  assign dec_x_s  = a_s ^ ENC_KEY;

  // Fetch, decode, execute and next-PC selection.
  always_comb begin
    instruction_out = imem[pc_r[10:0]];
    opcode_out      = instruction_out[18:15];
    rd_out          = instruction_out[14:11];
    rs1_out         = instruction_out[10:7];
    rs2_out         = instruction_out[6:3];
    alu_op_out      = instruction_out[2:0];
    funct2_out      = instruction_out[1:0];
    jump_addr_out   = instruction_out[10:0];
    call_addr_out   = instruction_out[10:0];
    branch_addr_out = instruction_out[7:0];
    readdata1_out   = (rs1_out == 4'd0) ? 19'd0 : regs[rs1_out];
    readdata2_out   = (rs2_out == 4'd0) ? 19'd0 : regs[rs2_out];
    alu_b_out       = readdata2_out;
    mem_addr_out    = readdata1_out[7:0];
    mem_data_out    = dmem[mem_addr_out];
    pc_out          = pc_r;
    sp_out          = sp_r;
    zero_out        = zero_r;
    stack_empty_out = (sp_r == 5'd0);
    stack_full_out  = (sp_r == 5'd16);
    stack_top_out   = stack_empty_out ? 19'd0 : stack[sp_r[3:0] - 4'd1];

    alu_use_out   = (opcode_out == OP_ARITH) || (opcode_out == OP_LOGIC);
    alu_type_out  = alu_use_out ? opcode_out[2:0] : 3'd0;
    branch_en_out = (opcode_out == OP_BEQ) || (opcode_out == OP_BNE);
    jump_en_out   = (opcode_out == OP_JMP);
    mem_read_out  = (opcode_out == OP_LOAD);
    mem_write_out = (opcode_out == OP_STORE);
    call_en_out   = (opcode_out == OP_CALL);
    ret_en_out    = (opcode_out == OP_RET);
    encr_en_out   = (opcode_out == OP_ENC);
    decr_en_out   = (opcode_out == OP_DEC);
    fft_en_out    = (opcode_out == OP_FFT);
    regwrite_out  = alu_use_out || mem_read_out || encr_en_out || decr_en_out ||
                    fft_en_out || (opcode_out == OP_LI);

    case (opcode_out)
      4'h0, 4'hF, OP_ARITH, OP_LOGIC, OP_LI, OP_HALT: type_out = 3'd0;
      OP_LOAD, OP_STORE: type_out = 3'd1;
      OP_BEQ, OP_BNE:    type_out = 3'd2;
      OP_JMP:            type_out = 3'd3;
      OP_CALL, OP_RET:   type_out = 3'd4;
      OP_ENC, OP_DEC:    type_out = 3'd5;
      OP_FFT:            type_out = 3'd6;
      default:           type_out = 3'd7;
    endcase
    if (!alu_use_out && (type_out == 3'd0)) type_out = 3'd7;
    else type_out = type_out;

    result_out = 19'd0;
    if (opcode_out == OP_ARITH) begin
      case (alu_op_out)
        3'd0:    result_out = a_s + b_s;
        3'd1:    result_out = a_s - b_s;
        3'd2:    result_out = a_s * b_s;
        3'd3:    result_out = (b_s == 19'd0) ? 19'h7FFFF : a_s / b_s;
        3'd4:    result_out = a_s + 19'd1;
        3'd5:    result_out = a_s - 19'd1;
        default: result_out = 19'd0;
      endcase
    end else if (opcode_out == OP_LOGIC) begin
      case (alu_op_out)
        3'd0:    result_out = a_s & b_s;
        3'd1:    result_out = a_s | b_s;
        3'd2:    result_out = a_s ^ b_s;
        3'd3:    result_out = ~a_s;
        3'd4:    result_out = (shamt_s >= 5'd19) ? 19'd0 : (a_s << shamt_s);
        3'd5:    result_out = (shamt_s >= 5'd19) ? 19'd0 : (a_s >> shamt_s);
        default: result_out = 19'd0;
      endcase
    end else begin
      result_out = 19'd0;
    end

    encr_result_out = decr_en_out ? {dec_x_s[2:0], dec_x_s[18:3]} : enc_s;
    fft_result_out  = alu_op_out[0] ? (a_s - b_s) : (a_s + b_s);

    case (opcode_out)
      OP_LOAD:        write_data_out = mem_data_out;
      OP_ENC, OP_DEC: write_data_out = encr_result_out;
      OP_FFT:         write_data_out = fft_result_out;
      OP_LI:          write_data_out = {8'd0, instruction_out[10:0]};
      default:        write_data_out = result_out;
    endcase

    pc_src_out  = 2'd0;
    pc_next_out = pc_inc_s;
    if (((opcode_out == OP_BEQ) && zero_r) || ((opcode_out == OP_BNE) && !zero_r)) begin
      pc_src_out  = 2'd1;
      pc_next_out = {11'd0, branch_addr_out};
    end else if (jump_en_out || (call_en_out && !stack_full_out)) begin
      pc_src_out  = 2'd2;
      pc_next_out = {8'd0, instruction_out[10:0]};
    end else if (ret_en_out && !stack_empty_out) begin
      pc_src_out  = 2'd3;
      pc_next_out = stack_top_out;
    end else if (opcode_out == OP_HALT) begin
      pc_next_out = pc_r;
    end else begin
      pc_next_out = pc_inc_s;
    end
  end

  // Architectural state update: PC, registers, data RAM, return stack, zero flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r   <= 19'd0;
      sp_r   <= 5'd0;
      zero_r <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= 19'd0;
      for (int i = 0; i < 256; i++) dmem[i] <= 19'd0;
    end else begin
      pc_r <= pc_next_out;
      if (regwrite_out && (rd_out != 4'd0)) regs[rd_out] <= write_data_out;
      if (mem_write_out) dmem[mem_addr_out] <= readdata2_out;
      if (alu_use_out) zero_r <= (result_out == 19'd0);
      if (call_en_out && !stack_full_out) begin
        stack[sp_r[3:0]] <= pc_inc_s;
        sp_r             <= sp_r + 5'd1;
      end else if (ret_en_out && !stack_empty_out) begin
        sp_r <= sp_r - 5'd1;
      end
    end
  end
endmodule

// File: tb/tb_cpu19_core.sv
// Directed self-checking bench for cpu19_core; program is placed into the ROM
// hierarchically and each task checks a feature with hand-computed values.
module tb_cpu19_core;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [18:0] instruction_out, readdata1_out, readdata2_out, alu_b_out, result_out;
  logic [18:0] mem_data_out, write_data_out, encr_result_out, fft_result_out;
  logic [18:0] pc_out, pc_next_out, stack_top_out;
  logic [3:0]  opcode_out, rd_out, rs1_out, rs2_out;
  logic [2:0]  alu_op_out, alu_type_out, type_out;
  logic [1:0]  funct2_out, pc_src_out;
  logic [10:0] jump_addr_out, call_addr_out;
  logic [7:0]  branch_addr_out, mem_addr_out;
  logic        regwrite_out, alu_use_out, branch_en_out, jump_en_out, mem_read_out;
  logic        mem_write_out, call_en_out, ret_en_out, encr_en_out, decr_en_out, fft_en_out;
  logic        zero_out, stack_empty_out, stack_full_out;
  logic [4:0]  sp_out;
  int tests = 0;
  int failed = 0;

  cpu19_core #(.IMEM_FILE(""), .ENC_KEY(19'h5A5A5)) dut (
    .clk(clk), .reset(reset), .instruction_out(instruction_out), .opcode_out(opcode_out),
    .rd_out(rd_out), .rs1_out(rs1_out), .rs2_out(rs2_out), .alu_op_out(alu_op_out),
    .funct2_out(funct2_out), .alu_type_out(alu_type_out), .type_out(type_out),
    .jump_addr_out(jump_addr_out), .call_addr_out(call_addr_out),
    .branch_addr_out(branch_addr_out), .mem_addr_out(mem_addr_out),
    .readdata1_out(readdata1_out), .readdata2_out(readdata2_out), .alu_b_out(alu_b_out),
    .result_out(result_out), .mem_data_out(mem_data_out), .write_data_out(write_data_out),
    .encr_result_out(encr_result_out), .fft_result_out(fft_result_out),
    .regwrite_out(regwrite_out), .alu_use_out(alu_use_out), .branch_en_out(branch_en_out),
    .jump_en_out(jump_en_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .call_en_out(call_en_out), .ret_en_out(ret_en_out), .encr_en_out(encr_en_out),
    .decr_en_out(decr_en_out), .fft_en_out(fft_en_out), .pc_src_out(pc_src_out),
    .zero_out(zero_out), .pc_out(pc_out), .pc_next_out(pc_next_out), .sp_out(sp_out),
    .stack_top_out(stack_top_out), .stack_empty_out(stack_empty_out),
    .stack_full_out(stack_full_out)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [2:0] aop);
    return {op, rd, rs1, rs2, aop};
  endfunction

  function automatic logic [18:0] ins_a(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [10:0] imm);
    return {op, rd, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_program();
    dut.imem[0]     = ins_a(4'hD, 4'd1, 11'd5);
    dut.imem[1]     = ins_a(4'hD, 4'd2, 11'd3);
    dut.imem[2]     = ins(4'h1, 4'd3, 4'd1, 4'd2, 3'd0);
    dut.imem[3]     = ins(4'h1, 4'd4, 4'd1, 4'd1, 3'd1);
    dut.imem[4]     = ins_a(4'h7, 4'd0, 11'h030);
    dut.imem[5]     = ins_a(4'h6, 4'd0, 11'h020);
    dut.imem[32'h20] = ins(4'h4, 4'd0, 4'd0, 4'd3, 3'd0);
    dut.imem[32'h21] = ins(4'h3, 4'd5, 4'd0, 4'd0, 3'd0);
    dut.imem[32'h22] = ins(4'hA, 4'd6, 4'd1, 4'd0, 3'd0);
    dut.imem[32'h23] = ins(4'hB, 4'd7, 4'd6, 4'd0, 3'd0);
    dut.imem[32'h24] = ins(4'hC, 4'd8, 4'd1, 4'd2, 3'd0);
    dut.imem[32'h25] = ins(4'hC, 4'd9, 4'd1, 4'd2, 3'd1);
    dut.imem[32'h26] = ins(4'h1, 4'd10, 4'd1, 4'd0, 3'd3);
    dut.imem[32'h27] = ins(4'h2, 4'd11, 4'd1, 4'd2, 3'd4);
    dut.imem[32'h28] = ins_a(4'hD, 4'd12, 11'd19);
    dut.imem[32'h29] = ins(4'h2, 4'd13, 4'd1, 4'd12, 3'd4);
    dut.imem[32'h2A] = ins(4'h1, 4'd14, 4'd5, 4'd7, 3'd2);
    dut.imem[32'h2B] = ins(4'h9, 4'd0, 4'd0, 4'd0, 3'd0);
    dut.imem[32'h2C] = ins_a(4'h8, 4'd0, 11'h100);
    for (int i = 0; i < 15; i++) dut.imem[32'h100 + i] = ins_a(4'h8, 4'd0, 11'h101 + 11'(i));
    dut.imem[32'h10F] = ins_a(4'h8, 4'd0, 11'h200);
    dut.imem[32'h110] = ins(4'h9, 4'd0, 4'd0, 4'd0, 3'd0);
    dut.imem[32'h200] = ins(4'hE, 4'd0, 4'd0, 4'd0, 3'd0);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++; if (pc_out !== 19'd0) begin $display("FAIL rst_pc actual=%h expected=0", pc_out); failed++; end
    tests++; if (sp_out !== 5'd0 || stack_empty_out !== 1'b1) begin $display("FAIL rst_sp actual=%0d/%b expected=0/1", sp_out, stack_empty_out); failed++; end
    tests++; if (zero_out !== 1'b0) begin $display("FAIL rst_zero actual=%b expected=0", zero_out); failed++; end
    tests++; if (rd_out !== 4'd1 || write_data_out !== 19'd5 || regwrite_out !== 1'b1) begin $display("FAIL rst_decode actual=rd%0d wd%h we%b expected=rd1 wd5 we1", rd_out, write_data_out, regwrite_out); failed++; end
    reset = 1'b0;
  endtask

  task automatic test_alu();
    step();
    tests++; if (pc_out !== 19'd1) begin $display("FAIL pc_1 actual=%h expected=1", pc_out); failed++; end
    step();
    tests++; if (pc_out !== 19'd2 || readdata1_out !== 19'd5 || readdata2_out !== 19'd3) begin $display("FAIL add_ops actual=pc%h a%h b%h expected=pc2 a5 b3", pc_out, readdata1_out, readdata2_out); failed++; end
    tests++; if (result_out !== 19'd8 || write_data_out !== 19'd8 || alu_type_out !== 3'd1 || type_out !== 3'd0) begin $display("FAIL add_res actual=%h/%h t%0d/%0d expected=8/8 t1/0", result_out, write_data_out, alu_type_out, type_out); failed++; end
    step();
    tests++; if (pc_out !== 19'd3 || zero_out !== 1'b0 || result_out !== 19'd0) begin $display("FAIL sub actual=pc%h z%b r%h expected=pc3 z0 r0", pc_out, zero_out, result_out); failed++; end
  endtask

  task automatic test_branch();
    step();
    tests++; if (zero_out !== 1'b1 || pc_next_out !== 19'd5 || pc_src_out !== 2'd0) begin $display("FAIL bne_nt actual=z%b nx%h src%0d expected=z1 nx5 src0", zero_out, pc_next_out, pc_src_out); failed++; end
    step();
    tests++; if (pc_out !== 19'd5 || pc_next_out !== 19'h20 || pc_src_out !== 2'd1) begin $display("FAIL beq_t actual=pc%h nx%h src%0d expected=pc5 nx20 src1", pc_out, pc_next_out, pc_src_out); failed++; end
    step();
    tests++; if (pc_out !== 19'h20) begin $display("FAIL beq_pc actual=%h expected=20", pc_out); failed++; end
  endtask

  task automatic test_mem();
    tests++; if (mem_write_out !== 1'b1 || mem_read_out !== 1'b0 || mem_addr_out !== 8'd0 || readdata2_out !== 19'd8) begin $display("FAIL store actual=w%b r%b a%h d%h expected=w1 r0 a0 d8", mem_write_out, mem_read_out, mem_addr_out, readdata2_out); failed++; end
    step();
    tests++; if (mem_read_out !== 1'b1 || mem_write_out !== 1'b0 || mem_data_out !== 19'd8 || write_data_out !== 19'd8) begin $display("FAIL load actual=r%b w%b md%h wd%h expected=r1 w0 md8 wd8", mem_read_out, mem_write_out, mem_data_out, write_data_out); failed++; end
  endtask

  task automatic test_crypto();
    step();
    tests++; if (encr_en_out !== 1'b1 || decr_en_out !== 1'b0 || write_data_out !== 19'h5A58D) begin $display("FAIL enc actual=e%b d%b wd%h expected=e1 d0 wd5a58d", encr_en_out, decr_en_out, write_data_out); failed++; end
    step();
    tests++; if (decr_en_out !== 1'b1 || encr_en_out !== 1'b0 || readdata1_out !== 19'h5A58D || encr_result_out !== 19'd5) begin $display("FAIL dec actual=d%b e%b in%h out%h expected=d1 e0 in5a58d out5", decr_en_out, encr_en_out, readdata1_out, encr_result_out); failed++; end
  endtask

  task automatic test_fft_div();
    step();
    tests++; if (fft_en_out !== 1'b1 || fft_result_out !== 19'd8 || type_out !== 3'd6) begin $display("FAIL fft_sum actual=en%b r%h t%0d expected=en1 r8 t6", fft_en_out, fft_result_out, type_out); failed++; end
    step();
    tests++; if (fft_result_out !== 19'd2 || write_data_out !== 19'd2) begin $display("FAIL fft_diff actual=%h/%h expected=2/2", fft_result_out, write_data_out); failed++; end
    step();
    tests++; if (result_out !== 19'h7FFFF) begin $display("FAIL div0 actual=%h expected=7ffff", result_out); failed++; end
    step();
    tests++; if (result_out !== 19'd40 || zero_out !== 1'b0) begin $display("FAIL sll3 actual=r%h z%b expected=r28 z0", result_out, zero_out); failed++; end
    step();
    step();
    tests++; if (readdata2_out !== 19'd19 || result_out !== 19'd0) begin $display("FAIL sll19 actual=b%h r%h expected=b13 r0", readdata2_out, result_out); failed++; end
    step();
    tests++; if (zero_out !== 1'b1 || result_out !== 19'd40) begin $display("FAIL mul_r5r7 actual=z%b r%h expected=z1 r28", zero_out, result_out); failed++; end
  endtask

  task automatic test_stack();
    step();
    tests++; if (pc_out !== 19'h2B || stack_empty_out !== 1'b1 || pc_next_out !== 19'h2C || pc_src_out !== 2'd0) begin $display("FAIL ret_empty actual=pc%h e%b nx%h src%0d expected=pc2b e1 nx2c src0", pc_out, stack_empty_out, pc_next_out, pc_src_out); failed++; end
    step();
    tests++; if (call_en_out !== 1'b1 || pc_next_out !== 19'h100 || pc_src_out !== 2'd2) begin $display("FAIL call1 actual=c%b nx%h src%0d expected=c1 nx100 src2", call_en_out, pc_next_out, pc_src_out); failed++; end
    step();
    tests++; if (sp_out !== 5'd1 || stack_top_out !== 19'h2D) begin $display("FAIL push1 actual=sp%0d top%h expected=sp1 top2d", sp_out, stack_top_out); failed++; end
    repeat (15) step();
    tests++; if (pc_out !== 19'h10F || sp_out !== 5'd16 || stack_full_out !== 1'b1 || stack_top_out !== 19'h10F) begin $display("FAIL full actual=pc%h sp%0d f%b top%h expected=pc10f sp16 f1 top10f", pc_out, sp_out, stack_full_out, stack_top_out); failed++; end
    tests++; if (pc_next_out !== 19'h110) begin $display("FAIL call17 actual=%h expected=110", pc_next_out); failed++; end
    step();
    tests++; if (pc_out !== 19'h110 || sp_out !== 5'd16 || pc_next_out !== 19'h10F || pc_src_out !== 2'd3) begin $display("FAIL ret actual=pc%h sp%0d nx%h src%0d expected=pc110 sp16 nx10f src3", pc_out, sp_out, pc_next_out, pc_src_out); failed++; end
    step();
    tests++; if (pc_out !== 19'h10F || sp_out !== 5'd15 || stack_top_out !== 19'h10E || stack_full_out !== 1'b0) begin $display("FAIL pop actual=pc%h sp%0d top%h f%b expected=pc10f sp15 top10e f0", pc_out, sp_out, stack_top_out, stack_full_out); failed++; end
  endtask

  task automatic test_halt();
    step();
    tests++; if (pc_out !== 19'h200 || sp_out !== 5'd16 || stack_top_out !== 19'h110) begin $display("FAIL repush actual=pc%h sp%0d top%h expected=pc200 sp16 top110", pc_out, sp_out, stack_top_out); failed++; end
    step();
    tests++; if (pc_out !== 19'h200 || pc_next_out !== 19'h200) begin $display("FAIL halt actual=pc%h nx%h expected=200/200", pc_out, pc_next_out); failed++; end
  endtask

  initial begin
    #1;
    load_program();
    test_reset();
    test_alu();
    test_branch();
    test_mem();
    test_crypto();
    test_fft_div();
    test_stack();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
